decode_instruction: RTL and testbench
=====================================

Name: decode_instruction

Overview:
- Instruction-decode stage of the single-cycle/pipelined core.
- Splits a 32-bit instruction word into opcode, three register indices and a 13-bit offset.
- Also produces a sign-extended immediate and per-class control flags.
- All outputs are registered: one cycle of latency, valid-qualified, between fetch and register-file/ALU.

Parameters:
- XLEN, 32, instruction and immediate width (fixed; not for override).
- REG_W, 5, register index width.
- OFF_W, 13, offset field width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  instruction is valid this cycle.
- instruction  input  32  raw instruction word.
- out_valid  output  1  decoded fields valid.
- opcode  output  4  instruction[3:0].
- reg_d  output  5  instruction[8:4], destination register.
- reg_a  output  5  instruction[13:9], source A.
- reg_b  output  5  instruction[18:14], source B.
- offset  output  13  instruction[31:19], raw offset.
- imm  output  32  offset sign-extended (bit 12 replicated).
- is_alu  output  1  register-register ALU op.
- uses_imm  output  1  operand B comes from imm.
- is_load  output  1  load.
- is_store  output  1  store.
- is_branch  output  1  conditional branch.
- is_jump  output  1  jump-and-link.
- reg_write  output  1  writes reg_d.
- illegal  output  1  reserved opcode.

Behaviour:
- Reset (rst_n low, asynchronous): every output goes to 0, including out_valid. Release is synchronous to clk.
- Each rising edge, with in_valid=1: all outputs are loaded from a combinational decode of instruction, and out_valid=1.
- Each rising edge, with in_valid=0: out_valid=0. All field and flag outputs keep their previous values.
- Latency is exactly 1 cycle. Back-to-back valid inputs produce back-to-back valid outputs. No backpressure.
- Field extraction is pure bit slicing with no dependence on opcode.
- imm = {{19{instruction[31]}}, instruction[31:19]}.
- Opcode map:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT: is_alu=1, reg_write=1.
  - 6 ADDI: uses_imm=1, reg_write=1.
  - 7 LW: is_load=1, uses_imm=1, reg_write=1.
  - 8 SW: is_store=1, uses_imm=1, reg_write=0.
  - 9 BEQ, A BNE: is_branch=1, reg_write=0.
  - B JAL: is_jump=1, reg_write=1.
  - F NOP: all flags 0, illegal=0.
  - C, D, E: illegal=1, all other flags 0.
- Writes to reg_d=0 are not suppressed here; the register file ignores writes to r0.
- A reset asserted mid-operation clears a pending out_valid immediately.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OP_ADD … OP_NOP);
  - field bit-position constants;
  - a decoded-instruction struct typedef.
- Sub-module decode_fields: combinational slicing, sign extension and the opcode-to-flag table.
- The top level adds only the output register and out_valid.

Test Plan:
- Reset: hold rst_n=0 with instruction=0x00308193 and in_valid=1 -> all outputs 0, out_valid=0. Release rst_n; next edge gives out_valid=1.
- 0x00008610, in_valid=1 -> one edge later: opcode=0, reg_d=1, reg_a=3, reg_b=2, offset=0, imm=0, is_alu=1, reg_write=1.
- 0x0001C670 -> opcode=0, reg_d=7, reg_a=3, reg_b=7, offset=0.
- 0x00308193 -> opcode=3, reg_d=0x19, reg_a=0, reg_b=2, offset=6, imm=6, is_alu=1.
- Sign extension, 0xFFF80006 -> opcode=6, offset=0x1FFF, imm=0xFFFFFFFF, uses_imm=1, reg_write=1.
- Illegal and hold:
  - 0x0000000D -> illegal=1, reg_write=0.
  - Then in_valid=0 for 2 cycles -> out_valid=0 and fields unchanged.
  - Assert rst_n low between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared opcode map, field positions and decoded-instruction record
package decode_pkg;

    localparam int XLEN  = 32;
    localparam int REG_W = 5;
    localparam int OFF_W = 13;

    localparam int OP_LSB  = 0;
    localparam int RD_LSB  = 4;
    localparam int RA_LSB  = 9;
    localparam int RB_LSB  = 14;
    localparam int OFF_LSB = 19;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLT  = 4'h5;
    localparam logic [3:0] OP_ADDI = 4'h6;
    localparam logic [3:0] OP_LW   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_BNE  = 4'hA;
    localparam logic [3:0] OP_JAL  = 4'hB;
    localparam logic [3:0] OP_NOP  = 4'hF;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [REG_W-1:0] reg_d;
        logic [REG_W-1:0] reg_a;
        logic [REG_W-1:0] reg_b;
        logic [OFF_W-1:0] offset;
        logic [XLEN-1:0]  imm;
        logic             is_alu;
        logic             uses_imm;
        logic             is_load;
        logic             is_store;
        logic             is_branch;
        logic             is_jump;
        logic             reg_write;
        logic             illegal;
    } decoded_t;

endpackage

// File: rtl/decode_instruction_fields.sv
// decode_instruction_fields: combinational field slicing, sign extension and opcode-to-flag table
module decode_instruction_fields
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] instruction,
    output decoded_t        dec
);

    logic [3:0] op;

    assign op = instruction[OP_LSB +: 4];

    // slice fields independently of opcode and derive the class flags
    always_comb begin
        dec           = '0;
        dec.opcode    = op;
        dec.reg_d     = instruction[RD_LSB +: REG_W];
        dec.reg_a     = instruction[RA_LSB +: REG_W];
        dec.reg_b     = instruction[RB_LSB +: REG_W];
        dec.offset    = instruction[OFF_LSB +: OFF_W];
        dec.imm       = {{(XLEN-OFF_W){instruction[XLEN-1]}}, instruction[OFF_LSB +: OFF_W]};
        dec.is_alu    = op <= OP_SLT;
        dec.uses_imm  = op == OP_ADDI || op == OP_LW || op == OP_SW;
        dec.is_load   = op == OP_LW;
        dec.is_store  = op == OP_SW;
        dec.is_branch = op == OP_BEQ || op == OP_BNE;
        dec.is_jump   = op == OP_JAL;
        dec.reg_write = op <= OP_LW || op == OP_JAL;
        dec.illegal   = op > OP_JAL && op != OP_NOP;
    end

endmodule

// File: rtl/decode_instruction.sv
// decode_instruction: registered instruction decode stage with valid qualification
module decode_instruction
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    output logic        out_valid,
    output logic [3:0]  opcode,
    output logic [4:0]  reg_d,
    output logic [4:0]  reg_a,
    output logic [4:0]  reg_b,
    output logic [12:0] offset,
    output logic [31:0] imm,
    output logic        is_alu,
    output logic        uses_imm,
    output logic        is_load,
    output logic        is_store,
    output logic        is_branch,
    output logic        is_jump,
    output logic        reg_write,
    output logic        illegal
);

    decoded_t dec_d;
    decoded_t dec_q;
    logic     valid_q;

    decode_instruction_fields u_fields (
        .instruction (instruction),
        .dec         (dec_d)
    );

    // capture a new decode only on valid input; fields hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) dec_q <= dec_d;
        end
    end

    assign out_valid = valid_q;
    assign opcode    = dec_q.opcode;
    assign reg_d     = dec_q.reg_d;
    assign reg_a     = dec_q.reg_a;
    assign reg_b     = dec_q.reg_b;
    assign offset    = dec_q.offset;
    assign imm       = dec_q.imm;
    assign is_alu    = dec_q.is_alu;
    assign uses_imm  = dec_q.uses_imm;
    assign is_load   = dec_q.is_load;
    assign is_store  = dec_q.is_store;
    assign is_branch = dec_q.is_branch;
    assign is_jump   = dec_q.is_jump;
    assign reg_write = dec_q.reg_write;
    assign illegal   = dec_q.illegal;

endmodule

// File: tb/tb_decode_instruction.sv
// tb_decode_instruction: table-driven check of the registered decode stage
module tb_decode_instruction;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [3:0]  opcode;
    logic [4:0]  reg_d, reg_a, reg_b;
    logic [12:0] offset;
    logic [31:0] imm;
    logic        is_alu, uses_imm, is_load, is_store, is_branch, is_jump, reg_write, illegal;

    int tests = 0;
    int fails = 0;

    // flags packed as {is_alu, uses_imm, is_load, is_store, is_branch, is_jump, reg_write, illegal}
    typedef struct packed {
        logic [31:0] instr;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [12:0] off;
        logic [31:0] imm;
        logic [7:0]  fl;
    } vec_t;

    vec_t tbl[$];

    decode_instruction dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .instruction (instruction),
        .out_valid   (out_valid),
        .opcode      (opcode),
        .reg_d       (reg_d),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .offset      (offset),
        .imm         (imm),
        .is_alu      (is_alu),
        .uses_imm    (uses_imm),
        .is_load     (is_load),
        .is_store    (is_store),
        .is_branch   (is_branch),
        .is_jump     (is_jump),
        .reg_write   (reg_write),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [31:0] i, logic [3:0] o, logic [4:0] d, logic [4:0] a,
                                logic [4:0] b, logic [12:0] f, logic [31:0] m, logic [7:0] g);
        return '{i, o, d, a, b, f, m, g};
    endfunction

    task automatic check(string name, logic v, vec_t e);
        logic [72:0] got, exp;
        got = {out_valid, opcode, reg_d, reg_a, reg_b, offset, imm,
               is_alu, uses_imm, is_load, is_store, is_branch, is_jump, reg_write, illegal};
        exp = {v, e.op, e.rd, e.ra, e.rb, e.off, e.imm, e.fl};
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic apply(logic [31:0] i, logic v);
        @(negedge clk);
        instruction = i;
        in_valid    = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t zero, last;
        zero = '0;
        tbl.push_back(mk(32'h0000_8610, 4'h0, 5'd1,  5'd3, 5'd2, 13'h0000, 32'h0000_0000, 8'h82));
        tbl.push_back(mk(32'h0001_C670, 4'h0, 5'd7,  5'd3, 5'd7, 13'h0000, 32'h0000_0000, 8'h82));
        tbl.push_back(mk(32'h0030_8193, 4'h3, 5'h19, 5'd0, 5'd2, 13'h0006, 32'h0000_0006, 8'h82));
        tbl.push_back(mk(32'hFFF8_0006, 4'h6, 5'd0,  5'd0, 5'd0, 13'h1FFF, 32'hFFFF_FFFF, 8'h42));
        tbl.push_back(mk(32'h0000_0001, 4'h1, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h82));
        tbl.push_back(mk(32'h0000_0004, 4'h4, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h82));
        tbl.push_back(mk(32'h0000_0005, 4'h5, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h82));
        tbl.push_back(mk(32'h8000_0007, 4'h7, 5'd0,  5'd0, 5'd0, 13'h1000, 32'hFFFF_F000, 8'h62));
        tbl.push_back(mk(32'h7FF8_0008, 4'h8, 5'd0,  5'd0, 5'd0, 13'h0FFF, 32'h0000_0FFF, 8'h50));
        tbl.push_back(mk(32'h0000_0009, 4'h9, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h08));
        tbl.push_back(mk(32'h0000_000A, 4'hA, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h08));
        tbl.push_back(mk(32'h0000_000B, 4'hB, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h06));
        tbl.push_back(mk(32'h0000_000F, 4'hF, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h00));
        tbl.push_back(mk(32'h0000_000C, 4'hC, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h01));
        tbl.push_back(mk(32'h0000_000E, 4'hE, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h01));
        tbl.push_back(mk(32'h0000_000D, 4'hD, 5'd0,  5'd0, 5'd0, 13'h0000, 32'h0000_0000, 8'h01));

        rst_n       = 1'b0;
        in_valid    = 1'b1;
        instruction = 32'h0030_8193;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 1'b0, zero);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 1'b1, tbl[2]);

        foreach (tbl[k]) begin
            apply(tbl[k].instr, 1'b1);
            check($sformatf("vec%0d_%h", k, tbl[k].instr), 1'b1, tbl[k]);
        end

        last = tbl[tbl.size()-1];
        apply(32'h0000_8610, 1'b0);
        check("hold1", 1'b0, last);
        apply(32'h0000_8610, 1'b0);
        check("hold2", 1'b0, last);

        apply(32'h0030_8193, 1'b1);
        check("resume", 1'b1, tbl[2]);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b0, zero);
        @(posedge clk);
        #1;
        check("reset_stays", 1'b0, zero);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
